// File: rtl/rgb_stream_packer_pkg.sv
// Shared definitions for the RGB stream packer: channel width default,
// packed pixel width and the layout of one output buffer entry.
package rgb_stream_packer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int PIX_W     = 3 * DEF_WIDTH;

  // One buffered pixel: packed {R,G,B} plus its line/frame position tags.
  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             eol;
    logic             eof;
  } entry_t;

  // Bit count of a buffer entry for an arbitrary channel width, laid out
  // exactly like entry_t: {pix, eol, eof}.
  function automatic int entry_bits(input int width);
    return 3 * width + 2;
  endfunction

endpackage

// File: rtl/rgb_stream_packer_pixel_fifo.sv
// Small circular output buffer for tagged pixels. Pointers wrap naturally,
// occupancy is one bit wider than the pointers so full and empty differ.
// The head word reads as zero whenever the buffer is empty.
module rgb_stream_packer_pixel_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              is_empty;
  logic              push_ok;
  logic              pop_ok;

  assign is_empty  = (count == '0);
  assign full      = (count == COUNT_FULL);
  assign occupancy = count;
  assign pop_ok    = pop && !is_empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = is_empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs processed R/G/B channels into one word, tags each pixel with its
// end-of-line / end-of-frame position and buffers it for a downstream
// consumer with ready/valid flow control. Upstream cannot be stalled, so
// pixels arriving while the buffer is full are dropped and flagged, but
// the position counters still advance to keep frame geometry aligned.
module rgb_stream_packer
  import rgb_stream_packer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   r_data_in,
  input  logic [WIDTH-1:0]   g_data_in,
  input  logic [WIDTH-1:0]   b_data_in,
  input  logic               data_in_done,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic [3*WIDTH-1:0] out_data,
  output logic               out_valid,
  output logic               out_eol,
  output logic               out_eof,
  output logic               frame_done,
  output logic               overflow
);

  localparam int ENTRY_W = entry_bits(WIDTH);
  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               is_eol;
  logic               is_eof;
  logic               fifo_full;
  logic [OCC_W-1:0]   occupancy;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               push;
  logic               pop;
  logic               drop;

  assign is_eol    = (col == COL_LAST);
  assign is_eof    = is_eol && (row == ROW_LAST);
  assign push_data = {r_data_in, g_data_in, b_data_in, is_eol, is_eof};

  assign out_valid = (occupancy != '0);
  assign out_data  = head_data[ENTRY_W-1:2];
  assign out_eol   = head_data[1];
  assign out_eof   = head_data[0];

  assign pop  = out_valid && out_ready;
  assign push = data_in_done && (!fifo_full || pop);
  assign drop = data_in_done && fifo_full && !pop;

  rgb_stream_packer_pixel_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) pixel_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .occupancy (occupancy)
  );

  // Frame position counters advance on every strobe, dropped pixels included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (data_in_done) begin
      if (is_eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // One-cycle pulse after the last pixel of a frame leaves the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_done <= 1'b0;
    else        frame_done <= pop && out_eof;
  end

  // Sticky drop flag; a new drop takes priority over a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed testbench for rgb_stream_packer with a 4x2 frame and 4-entry buffer.
module tb_rgb_stream_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  r_data_in, g_data_in, b_data_in;
  logic        data_in_done, out_ready, ovf_clr;
  logic [23:0] out_data;
  logic        out_valid, out_eol, out_eof, frame_done, overflow;

  int total = 0;
  int bad   = 0;

  rgb_stream_packer #(
    .WIDTH(8), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .r_data_in(r_data_in), .g_data_in(g_data_in), .b_data_in(b_data_in),
    .data_in_done(data_in_done), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_valid(out_valid), .out_eol(out_eol),
    .out_eof(out_eof), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, b, b};
  endfunction

  task automatic set_pix(input int k);
    r_data_in = k[7:0];
    g_data_in = k[7:0];
    b_data_in = k[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; data_in_done = 0; out_ready = 0; ovf_clr = 0; set_pix(0);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 24'h0) begin bad++; $display("[TB] FAIL reset_data got=%h want=000000", out_data); end
    total++; if (overflow !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b%b want=00", overflow, frame_done); end
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic eol_w, eof_w;
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      set_pix(k); data_in_done = 1;
      tick();
      eol_w = (k % 4 == 0); eof_w = (k == 8);
      total++; if (out_valid !== 1'b1 || out_data !== pix(k)) begin bad++; $display("[TB] FAIL stream_data k=%0d got=%b/%h want=1/%h", k, out_valid, out_data, pix(k)); end
      total++; if (out_eol !== eol_w || out_eof !== eof_w) begin bad++; $display("[TB] FAIL stream_tags k=%0d got=%b%b want=%b%b", k, out_eol, out_eof, eol_w, eof_w); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL stream_fd_early k=%0d got=%b want=0", k, frame_done); end
    end
    data_in_done = 0;
    tick();
    total++; if (out_valid !== 1'b0 || frame_done !== 1'b1) begin bad++; $display("[TB] FAIL stream_end got=%b/%b want=0/1", out_valid, frame_done); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL stream_fd_pulse got=%b want=0", frame_done); end
  endtask

  task automatic test_overflow();
    out_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      set_pix(k); data_in_done = 1;
      tick();
      if (k == 4) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_before got=%b want=0", overflow); end
      end
      if (k == 5) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b want=1", overflow); end
      end
    end
    data_in_done = 0; out_ready = 1;
    for (int j = 1; j <= 4; j++) begin
      total++; if (out_valid !== 1'b1 || out_data !== pix(j)) begin bad++; $display("[TB] FAIL ovf_drain j=%0d got=%b/%h want=1/%h", j, out_valid, out_data, pix(j)); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_empty got=%b want=0", out_valid); end
    set_pix(9); data_in_done = 1;
    tick();
    total++; if (out_data !== pix(9) || out_eol !== 1'b0 || out_eof !== 1'b0) begin bad++; $display("[TB] FAIL ovf_col2 got=%h %b%b want=%h 00", out_data, out_eol, out_eof, pix(9)); end
    set_pix(10);
    tick();
    total++; if (out_data !== pix(10) || out_eol !== 1'b1 || out_eof !== 1'b1) begin bad++; $display("[TB] FAIL ovf_col3 got=%h %b%b want=%h 11", out_data, out_eol, out_eof, pix(10)); end
    data_in_done = 0;
    tick();
    total++; if (frame_done !== 1'b1 || overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_frame got=%b/%b want=1/1", frame_done, overflow); end
  endtask

  task automatic test_full_push_pop();
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL fpp_clear got=%b want=0", overflow); end
    out_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      set_pix(k); data_in_done = 1;
      tick();
    end
    out_ready = 1; set_pix(5);
    tick();
    data_in_done = 0;
    total++; if (out_data !== pix(2) || overflow !== 1'b0) begin bad++; $display("[TB] FAIL fpp_accept got=%h/%b want=%h/0", out_data, overflow, pix(2)); end
    for (int j = 2; j <= 5; j++) begin
      total++; if (out_valid !== 1'b1 || out_data !== pix(j)) begin bad++; $display("[TB] FAIL fpp_drain j=%0d got=%b/%h want=1/%h", j, out_valid, out_data, pix(j)); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL fpp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_ovf_clr();
    out_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      set_pix(k); data_in_done = 1;
      tick();
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL clr_set got=%b want=1", overflow); end
    set_pix(6); ovf_clr = 1;
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL clr_set_wins got=%b want=1", overflow); end
    data_in_done = 0;
    tick();
    ovf_clr = 0;
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL clr_alone got=%b want=0", overflow); end
    total++; if (out_data !== pix(1)) begin bad++; $display("[TB] FAIL clr_head got=%h want=%h", out_data, pix(1)); end
    out_ready = 1;
    repeat (4) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      set_pix(k); data_in_done = 1;
      tick();
    end
    data_in_done = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rmid_pre got=%b want=1", out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 24'h0) begin bad++; $display("[TB] FAIL rmid_async got=%b/%h want=0/000000", out_valid, out_data); end
    tick();
    reset = 1'b1;
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      set_pix(k); data_in_done = 1;
      tick();
      total++; if (out_data !== pix(k) || out_eol !== (k == 4) || out_eof !== 1'b0) begin bad++; $display("[TB] FAIL rmid_tag k=%0d got=%h %b%b want=%h %b0", k, out_data, out_eol, out_eof, pix(k), (k == 4)); end
    end
    data_in_done = 0;
    tick();
  endtask

  task automatic test_toggle();
    int exp_k = 1;
    int fd_count = 0;
    reset = 1'b0;
    #2 reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 0);
      if (out_valid) begin
        total++; if (out_data !== pix(exp_k) || out_eol !== (exp_k % 4 == 0) || out_eof !== (exp_k == 8)) begin bad++; $display("[TB] FAIL toggle_data c=%0d got=%h %b%b want=%h", c, out_data, out_eol, out_eof, pix(exp_k)); end
        if (out_ready) exp_k++;
      end
      data_in_done = (c < 16) && (c % 2 == 0);
      set_pix(c / 2 + 1);
      tick();
      if (frame_done) fd_count++;
    end
    data_in_done = 0;
    total++; if (exp_k !== 9) begin bad++; $display("[TB] FAIL toggle_count got=%0d want=9", exp_k); end
    total++; if (fd_count !== 1) begin bad++; $display("[TB] FAIL toggle_fd got=%0d want=1", fd_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL toggle_ovf got=%b want=0", overflow); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_ovf_clr();
    test_reset_mid();
    test_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
